// File: rtl/acc_sequencer_pkg.sv
// rtl/acc_sequencer_pkg.sv - shared types and limits for the accumulator sequencer
package acc_sequencer_pkg;
    localparam int CPLX_BITS   = 16;
    localparam int ACC_MIN_LEN = 12;
    localparam int ACC_MAX_LEN = 512;

    typedef struct packed {
        logic signed [CPLX_BITS-1:0] re;
        logic signed [CPLX_BITS-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;
endpackage

// File: rtl/acc_sequencer_if.sv
// rtl/acc_sequencer_if.sv - config, sample, accumulator and result signals of the sequencer
interface acc_sequencer_if
    import acc_sequencer_pkg::*;
#(
    parameter int LEN_BITS = 10,
    parameter int CNT_BITS = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [LEN_BITS-1:0] cfg_length;
    logic [CNT_BITS-1:0] cfg_count;
    logic                cfg_error;
    complex_t            in_data;
    logic                in_valid;
    logic                in_ready;
    complex_t            acc_in;
    logic                acc_start;
    logic                acc_stop;
    complex_t            acc_out;
    logic                acc_output_valid;
    complex_t            res_data;
    logic                res_valid;
    logic                res_ready;
    logic                res_last;
    logic                busy;
    logic                done;

    // slave is the sequencer itself; master is the surrounding source/accumulator/sink
    modport slave (
        input  cfg_valid, cfg_length, cfg_count, in_data, in_valid,
               acc_out, acc_output_valid, res_ready,
        output cfg_ready, cfg_error, in_ready, acc_in, acc_start, acc_stop,
               res_data, res_valid, res_last, busy, done
    );
    modport master (
        output cfg_valid, cfg_length, cfg_count, in_data, in_valid,
               acc_out, acc_output_valid, res_ready,
        input  cfg_ready, cfg_error, in_ready, acc_in, acc_start, acc_stop,
               res_data, res_valid, res_last, busy, done
    );
endinterface

// File: rtl/acc_result_fifo.sv
// rtl/acc_result_fifo.sv - small synchronous FIFO holding captured vector sums
module acc_result_fifo
    import acc_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  complex_t               i_data,
    input  logic                   i_pop,
    output complex_t               o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_occ
);
    localparam int AW = $clog2(DEPTH);

    complex_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_occ;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_occ == '0);
    assign o_full    = (r_occ == (AW+1)'(DEPTH));
    assign o_occ     = r_occ;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_occ <= r_occ + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end
endmodule

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - frames a complex sample stream into accumulator vectors
// and returns the per-vector sums through a credit-limited result FIFO.
module acc_sequencer
    import acc_sequencer_pkg::*;
#(
    parameter int LEN_BITS  = 10,
    parameter int CNT_BITS  = 8,
    parameter int RES_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    acc_sequencer_if.slave bus
);
    localparam int                  PW      = $clog2(RES_DEPTH) + 1;
    localparam logic [LEN_BITS-1:0] MIN_LEN = LEN_BITS'(ACC_MIN_LEN);
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(ACC_MAX_LEN);
    localparam logic [PW-1:0]       CREDITS = PW'(RES_DEPTH);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [LEN_BITS-1:0] r_length;
    logic [LEN_BITS-1:0] r_elem_cnt;
    logic [CNT_BITS-1:0] r_count;
    logic [CNT_BITS-1:0] r_vec_cnt;
    logic [CNT_BITS-1:0] r_res_cnt;
    logic [PW-1:0]       r_inflight;
    logic                r_cap_pending;
    logic                r_cfg_error;
    logic                r_acc_start;
    logic                r_acc_stop;
    complex_t            r_acc_in;

    logic                w_cfg_fire, w_cfg_bad, w_cfg_take;
    logic                w_in_ready, w_beat, w_vec_first, w_vec_last, w_run_last;
    logic                w_push, w_pop, w_all_captured;
    logic                w_cfg_ready, w_busy, w_done;
    logic                w_fifo_full, w_fifo_empty;
    logic [PW-1:0]       w_occ;
    complex_t            w_fifo_data;

    assign w_cfg_fire  = bus.cfg_valid && w_cfg_ready;
    assign w_cfg_bad   = (bus.cfg_length < MIN_LEN) || (bus.cfg_length > MAX_LEN) ||
                         (bus.cfg_count == '0);
    assign w_cfg_take  = w_cfg_fire && !w_cfg_bad;

    // A new vector may only start if its sum is guaranteed a FIFO slot.
    assign w_in_ready  = (r_state == ST_RUN) &&
                         ((r_elem_cnt != '0) || (!w_fifo_full && (w_occ + r_inflight < CREDITS)));
    assign w_beat      = bus.in_valid && w_in_ready;
    assign w_vec_first = (r_elem_cnt == '0);
    assign w_vec_last  = (r_elem_cnt == r_length - LEN_BITS'(1));
    assign w_run_last  = w_beat && w_vec_last && (r_vec_cnt + CNT_BITS'(1) == r_count);

    assign w_push         = r_cap_pending;
    assign w_pop          = !w_fifo_empty && bus.res_ready;
    assign w_all_captured = (r_inflight == '0) && (r_res_cnt == r_count);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_cfg_ready  = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cfg_ready = 1'b1;
                w_busy      = 1'b0;
                if (bus.cfg_valid && !w_cfg_bad) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_run_last) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_all_captured && (w_fifo_empty || (w_occ == PW'(1) && w_pop)))
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_length      <= '0;
            r_count       <= '0;
            r_elem_cnt    <= '0;
            r_vec_cnt     <= '0;
            r_res_cnt     <= '0;
            r_inflight    <= '0;
            r_cap_pending <= 1'b0;
            r_cfg_error   <= 1'b0;
            r_acc_in      <= '0;
            r_acc_start   <= 1'b0;
            r_acc_stop    <= 1'b0;
        end else begin
            r_cfg_error   <= w_cfg_fire && w_cfg_bad;
            // Gaps feed zeros so the running sum is unaffected by stalls.
            r_acc_in      <= w_beat ? bus.in_data : '0;
            r_acc_start   <= w_beat && w_vec_first;
            r_acc_stop    <= w_beat && w_vec_last;
            r_cap_pending <= bus.acc_output_valid;
            r_inflight    <= r_inflight + PW'(w_beat && w_vec_last) - PW'(w_push);
            if (w_push) r_res_cnt <= r_res_cnt + CNT_BITS'(1);
            if (w_cfg_take) begin
                r_length   <= bus.cfg_length;
                r_count    <= bus.cfg_count;
                r_elem_cnt <= '0;
                r_vec_cnt  <= '0;
                r_res_cnt  <= '0;
            end else if (w_beat) begin
                if (w_vec_last) begin
                    r_elem_cnt <= '0;
                    r_vec_cnt  <= r_vec_cnt + CNT_BITS'(1);
                end else begin
                    r_elem_cnt <= r_elem_cnt + LEN_BITS'(1);
                end
            end
        end
    end

    acc_result_fifo #(.DEPTH(RES_DEPTH)) u_result_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (bus.acc_out),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_occ   (w_occ)
    );

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.cfg_error = r_cfg_error;
    assign bus.in_ready  = w_in_ready;
    assign bus.acc_in    = r_acc_in;
    assign bus.acc_start = r_acc_start;
    assign bus.acc_stop  = r_acc_stop;
    assign bus.res_valid = !w_fifo_empty;
    assign bus.res_data  = w_fifo_empty ? '0 : w_fifo_data;
    // Once every sum is captured, the only entry left is the run's last one.
    assign bus.res_last  = !w_fifo_empty && (r_res_cnt == r_count) && (w_occ == PW'(1));
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
endmodule

// File: tb/tb_acc_sequencer.sv
// tb/tb_acc_sequencer.sv - randomized bench for acc_sequencer with accumulator and sum model
module tb_acc_sequencer;
    import acc_sequencer_pkg::*;

    localparam int LEN_BITS  = 10;
    localparam int CNT_BITS  = 8;
    localparam int RES_DEPTH = 4;
    localparam int BUDGET    = 5000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   pops  = 0;

    complex_t samples[$];
    complex_t exp_sums[$];
    complex_t m_sum;
    complex_t m_nxt;

    acc_sequencer_if #(.LEN_BITS(LEN_BITS), .CNT_BITS(CNT_BITS)) bus ();

    acc_sequencer #(.LEN_BITS(LEN_BITS), .CNT_BITS(CNT_BITS), .RES_DEPTH(RES_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic complex_t cplx(input int re, input int im);
        complex_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    function automatic complex_t cplx_add(input complex_t a, input complex_t b);
        complex_t c;
        c.re = a.re + b.re;
        c.im = a.im + b.im;
        return c;
    endfunction

    // Accumulator: sums acc_in from start, flags output_valid after stop,
    // and holds the finished sum on acc_out until the next stop.
    always @(posedge clk) begin
        if (reset) begin
            m_sum = '0;
            bus.acc_output_valid <= 1'b0;
            bus.acc_out          <= '0;
        end else begin
            m_nxt = bus.acc_start ? bus.acc_in : cplx_add(m_sum, bus.acc_in);
            m_sum = m_nxt;
            bus.acc_output_valid <= bus.acc_stop;
            if (bus.acc_stop) bus.acc_out <= m_nxt;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_cfg_error", 32'(bus.cfg_error), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_acc_in",    bus.acc_in,         32'd0);
        check("rst_acc_start", 32'(bus.acc_start), 32'd0);
        check("rst_acc_stop",  32'(bus.acc_stop),  32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_last",  32'(bus.res_last),  32'd0);
        check("rst_res_data",  bus.res_data,       32'd0);
    endtask

    // mode 0: random data, 1: constant 1+1j, 2: vector k carries (k+1)+0j
    task automatic make_run(input int len, input int cnt, input int mode);
        int sr, si, re, im;
        samples.delete();
        exp_sums.delete();
        for (int v = 0; v < cnt; v++) begin
            sr = 0;
            si = 0;
            for (int e = 0; e < len; e++) begin
                case (mode)
                    1:       begin re = 1;     im = 1; end
                    2:       begin re = v + 1; im = 0; end
                    default: begin
                        re = int'($urandom_range(200)) - 100;
                        im = int'($urandom_range(200)) - 100;
                    end
                endcase
                sr += re;
                si += im;
                samples.push_back(cplx(re, im));
            end
            exp_sums.push_back(cplx(sr, si));
        end
    endtask

    task automatic send_cfg(input int len, input int cnt);
        @(negedge clk);
        check("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);
        bus.cfg_valid  = 1'b1;
        bus.cfg_length = LEN_BITS'(len);
        bus.cfg_count  = CNT_BITS'(cnt);
        @(negedge clk);
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic bad_cfg(input int len, input int cnt);
        @(negedge clk);
        bus.cfg_valid  = 1'b1;
        bus.cfg_length = LEN_BITS'(len);
        bus.cfg_count  = CNT_BITS'(cnt);
        @(negedge clk);
        bus.cfg_valid  = 1'b0;
        check("cfg_error_pulse", 32'(bus.cfg_error), 32'd1);
        check("bad_cfg_busy",    32'(bus.busy),      32'd0);
        check("bad_cfg_start",   32'(bus.acc_start), 32'd0);
        @(negedge clk);
        check("cfg_error_clear", 32'(bus.cfg_error), 32'd0);
        check("bad_cfg_idle",    32'(bus.cfg_ready), 32'd1);
    endtask

    task automatic drive_stream(input int len, input int total, input int gap_pct, input int gap_idx);
        int       idx = 0;
        int       cyc = 0;
        int       gap_cnt = 0;
        int       prev_idx = 0;
        bit       prev_beat = 1'b0;
        bit       exp_rdy;
        complex_t prev_data = '0;
        while (idx < total && cyc < BUDGET) begin
            check("acc_start", 32'(bus.acc_start), 32'(prev_beat && (prev_idx % len == 0)));
            check("acc_stop",  32'(bus.acc_stop),  32'(prev_beat && (prev_idx % len == len - 1)));
            check("acc_in",    bus.acc_in,         prev_beat ? prev_data : '0);
            if (idx == gap_idx && gap_cnt < 3) begin
                bus.in_valid = 1'b0;
                gap_cnt++;
            end else begin
                bus.in_valid = ($urandom_range(99) >= gap_pct);
            end
            bus.in_data = samples[idx];
            #1;
            exp_rdy = (idx % len != 0) || (idx / len - pops < RES_DEPTH);
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            prev_beat = bus.in_valid && bus.in_ready;
            prev_idx  = idx;
            prev_data = samples[idx];
            if (prev_beat) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (idx < total) begin
            check("stream_timeout", 32'(idx), 32'(total));
        end else begin
            check("acc_stop_last", 32'(bus.acc_stop), 32'(prev_beat && (prev_idx % len == len - 1)));
            check("acc_in_last",   bus.acc_in,        prev_data);
            check("in_ready_drain", 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic consume(input int cnt, input int hold, input int ready_pct);
        int k = 0;
        int cyc = 0;
        while (k < cnt && cyc < BUDGET) begin
            bus.res_ready = (cyc >= hold) && ($urandom_range(99) < ready_pct);
            #2;
            if (bus.res_valid && bus.res_ready) begin
                check("res_data", bus.res_data, exp_sums[k]);
                check("res_last", 32'(bus.res_last), 32'(k == cnt - 1));
                k++;
                pops++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.res_ready = 1'b0;
        if (k < cnt) begin
            check("result_timeout", 32'(k), 32'(cnt));
        end else begin
            check("done_pulse", 32'(bus.done), 32'd1);
            @(negedge clk);
            check("done_clear", 32'(bus.done),      32'd0);
            check("back_idle",  32'(bus.cfg_ready), 32'd1);
        end
    endtask

    task automatic run(input int len, input int cnt, input int mode, input int gap_pct,
                       input int gap_idx, input int hold, input int ready_pct);
        make_run(len, cnt, mode);
        pops = 0;
        send_cfg(len, cnt);
        fork
            drive_stream(len, len * cnt, gap_pct, gap_idx);
            consume(cnt, hold, ready_pct);
        join
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_length = '0;
        bus.cfg_count  = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.res_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        run(12, 1, 1, 0, -1, 0, 100);
        bad_cfg(11, 1);
        bad_cfg(513, 1);
        bad_cfg(16, 0);
        run(16, 2, 2, 0, 5, 0, 100);
        run(12, 8, 0, 0, -1, 200, 100);
        run(12, 10, 0, 0, -1, 0, 50);

        send_cfg(64, 2);
        bus.in_data = cplx(3, -2);
        for (int i = 0; i < 80; i++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        run(64, 2, 0, 10, -1, 0, 70);

        for (int r = 0; r < 6; r++) begin
            run(12 + int'($urandom_range(28)), 1 + int'($urandom_range(5)), 0, 25, -1,
                int'($urandom_range(30)), 50);
        end
        run(512, 1, 0, 5, -1, 0, 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
